// File: rtl/bufg_ctrl_pkg.sv
// bufg_ctrl_pkg: shared types for the clock-buffer switch sequencer.
// Holds the FSM state encoding and a width helper for the counters.
`timescale 1ns/1ps
package bufg_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DESEL,
        ST_SETTLE,
        ST_SEL,
        ST_CONFIRM,
        ST_REVERT
    } state_e;

    // Bits needed to hold values 0..v-1 (minimum 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_activity_mon.sv
// clk_activity_mon: watches a toggle derived from a remote clock.
// Ports: clk/rst_n control clock, tog_i remote toggle,
//        edge_o synchronized edge strobe, alive_o registered activity flag.
`timescale 1ns/1ps
module clk_activity_mon
    import bufg_ctrl_pkg::*;
#(
    parameter int unsigned ALIVE_WINDOW = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tog_i,
    output logic edge_o,
    output logic alive_o
);

    localparam int unsigned CW = clog2(ALIVE_WINDOW + 1);
    localparam logic [CW-1:0] WIN = CW'(ALIVE_WINDOW);

    logic [2:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          alive_q;

    // Either polarity of the synchronized toggle counts as activity.
    assign edge_o  = sync_q[2] ^ sync_q[1];
    assign alive_o = alive_q;

    always_comb begin
        cnt_d = cnt_q;
        if (edge_o)
            cnt_d = '0;
        else if (cnt_q != WIN)
            cnt_d = cnt_q + CW'(1);
    end

    // Counter starts saturated so the channel reads dead until it moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= WIN;
            alive_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], tog_i};
            cnt_q   <= cnt_d;
            alive_q <= (cnt_q < WIN);
        end
    end

endmodule

// File: rtl/bufg_switch_ctrl.sv
// bufg_switch_ctrl: glitch-free switchover sequencer for a 2-input clock mux.
// Ports: clk/rst_n, tog0/tog1 activity toggles, req_valid/req_sel/req_ready
//        request handshake, s0/s1/ce0/ce1/ignore0/ignore1 buffer pins,
//        sel_cur/alive0/alive1/busy/done/err status (all registered).
`timescale 1ns/1ps
module bufg_switch_ctrl
    import bufg_ctrl_pkg::*;
#(
    parameter bit          INIT_SEL      = 1'b0,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned ALIVE_WINDOW  = 64,
    parameter int unsigned CONFIRM_EDGES = 2,
    parameter int unsigned TIMEOUT       = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tog0,
    input  logic tog1,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    output logic s0,
    output logic s1,
    output logic ce0,
    output logic ce1,
    output logic ignore0,
    output logic ignore1,
    output logic sel_cur,
    output logic alive0,
    output logic alive1,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int unsigned SW = clog2(SETTLE_CYCLES + 1);
    localparam int unsigned EW = clog2(CONFIRM_EDGES + 1);
    localparam int unsigned TW = clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SET_L  = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] SET_M1 = SW'(SETTLE_CYCLES - 1);
    localparam logic [EW-1:0] CE_L   = EW'(CONFIRM_EDGES);
    localparam logic [EW-1:0] CE_M1  = EW'(CONFIRM_EDGES - 1);
    localparam logic [TW-1:0] TO_M1  = TW'(TIMEOUT - 1);

    logic [1:0] alive_w, edge_w;

    clk_activity_mon #(.ALIVE_WINDOW(ALIVE_WINDOW)) u_mon0 (
        .clk(clk), .rst_n(rst_n), .tog_i(tog0),
        .edge_o(edge_w[0]), .alive_o(alive_w[0])
    );

    clk_activity_mon #(.ALIVE_WINDOW(ALIVE_WINDOW)) u_mon1 (
        .clk(clk), .rst_n(rst_n), .tog_i(tog1),
        .edge_o(edge_w[1]), .alive_o(alive_w[1])
    );

    state_e        state_q, state_d;
    logic          new_q, new_d, old_q, old_d;
    logic          dold_q, dold_d, dnew_q, dnew_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [EW-1:0] ecnt_q, ecnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [1:0]    s_q, s_d, ign_q, ign_d, ce_q;
    logic          sel_q, sel_d, busy_q, busy_d;
    logic          done_q, done_d, err_q, err_d, rdy_q;

    always_comb begin
        state_d = state_q;
        new_d   = new_q;
        old_d   = old_q;
        dold_d  = dold_q;
        dnew_d  = dnew_q;
        cnt_d   = cnt_q;
        ecnt_d  = ecnt_q;
        tcnt_d  = tcnt_q;
        s_d     = s_q;
        ign_d   = ign_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_sel == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        // Liveness is frozen at accept time.
                        new_d   = req_sel;
                        old_d   = sel_q;
                        dold_d  = ~alive_w[sel_q];
                        dnew_d  = ~alive_w[req_sel];
                        busy_d  = 1'b1;
                        state_d = ST_DESEL;
                    end
                end
            end
            ST_DESEL: begin
                s_d[old_q]   = 1'b0;
                ign_d[old_q] = dold_q;
                ign_d[new_q] = dnew_q;
                cnt_d        = '0;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == SET_M1)
                    state_d = ST_SEL;
                else
                    cnt_d = cnt_q + SW'(1);
            end
            ST_SEL: begin
                s_d[new_q] = 1'b1;
                ecnt_d     = '0;
                tcnt_d     = '0;
                state_d    = ST_CONFIRM;
            end
            ST_CONFIRM: begin
                if (edge_w[new_q] && ecnt_q == CE_M1) begin
                    sel_d   = new_q;
                    ign_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    if (edge_w[new_q] && ecnt_q != CE_L)
                        ecnt_d = ecnt_q + EW'(1);
                    if (tcnt_q == TO_M1) begin
                        cnt_d   = '0;
                        state_d = ST_REVERT;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            ST_REVERT: begin
                // Both selects stay low for a full settle before going back.
                if (cnt_q == SET_L) begin
                    s_d[old_q]   = 1'b1;
                    ign_d[new_q] = 1'b0;
                    err_d        = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    s_d[new_q]   = 1'b0;
                    ign_d[new_q] = 1'b1;
                    cnt_d        = cnt_q + SW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            new_q   <= 1'b0;
            old_q   <= 1'b0;
            dold_q  <= 1'b0;
            dnew_q  <= 1'b0;
            cnt_q   <= '0;
            ecnt_q  <= '0;
            tcnt_q  <= '0;
            s_q     <= {INIT_SEL, ~INIT_SEL};
            ign_q   <= '0;
            ce_q    <= 2'b11;
            sel_q   <= INIT_SEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            new_q   <= new_d;
            old_q   <= old_d;
            dold_q  <= dold_d;
            dnew_q  <= dnew_d;
            cnt_q   <= cnt_d;
            ecnt_q  <= ecnt_d;
            tcnt_q  <= tcnt_d;
            s_q     <= s_d;
            ign_q   <= ign_d;
            ce_q    <= 2'b11;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdy_q   <= (state_d == ST_IDLE);
        end
    end

    assign req_ready = rdy_q;
    assign s0        = s_q[0];
    assign s1        = s_q[1];
    assign ce0       = ce_q[0];
    assign ce1       = ce_q[1];
    assign ignore0   = ign_q[0];
    assign ignore1   = ign_q[1];
    assign sel_cur   = sel_q;
    assign alive0    = alive_w[0];
    assign alive1    = alive_w[1];
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bufg_switch_ctrl.sv
// tb_bufg_switch_ctrl: directed checks of the clock switch sequencer.
// Drives toggles for both clocks, requests switches, checks pin timing.
`timescale 1ns/1ps
module tb_bufg_switch_ctrl;

    logic clk = 1'b0;
    logic rst_n, tog0, tog1, req_valid, req_sel;
    logic req_ready, s0, s1, ce0, ce1, ignore0, ignore1;
    logic sel_cur, alive0, alive1, busy, done, err;
    logic en0, en1, ig_seen;
    int   n_chk, n_fail, overlap;

    bufg_switch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tog0(tog0), .tog1(tog1),
        .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
        .s0(s0), .s1(s1), .ce0(ce0), .ce1(ce1),
        .ignore0(ignore0), .ignore1(ignore1), .sel_cur(sel_cur),
        .alive0(alive0), .alive1(alive1), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        tog0 = 1'b0;
        forever begin
            #35;
            if (en0) tog0 = ~tog0;
        end
    end

    initial begin
        tog1 = 1'b0;
        forever begin
            #45;
            if (en1) tog1 = ~tog1;
        end
    end

    always @(negedge clk) if (s0 && s1) overlap++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ig_seen = ig_seen | ignore0 | ignore1;
    endtask

    task automatic wait_alive(input string tag);
        for (int i = 0; i < 100 && !(alive0 && alive1); i++) step();
        chk(tag, 32'({alive1, alive0}), 32'h3);
    endtask

    task automatic wait_done(input string tag, input logic sel);
        logic seen;
        seen = done;
        for (int i = 0; i < 300 && !seen; i++) begin
            step();
            seen = done;
        end
        chk(tag, 32'(seen), 1);
        chk({tag, "_sel"}, 32'(sel_cur), 32'(sel));
    endtask

    task automatic do_switch(input logic sel);
        req_valid = 1'b1;
        req_sel   = sel;
        step();
        req_valid = 1'b0;
        wait_done("sw_done", sel);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; overlap = 0; ig_seen = 1'b0;
        rst_n = 1'b0; req_valid = 1'b0; req_sel = 1'b0;
        en0 = 1'b1; en1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s0", 32'(s0), 1);
        chk("rst_s1", 32'(s1), 0);
        chk("rst_ce", 32'({ce1, ce0}), 32'h3);
        chk("rst_ign", 32'({ignore1, ignore0}), 0);
        chk("rst_sel", 32'(sel_cur), 0);
        chk("rst_alive", 32'({alive1, alive0}), 0);
        chk("rst_stat", 32'({busy, done, err}), 0);
        chk("rst_rdy", 32'(req_ready), 1);
        rst_n = 1'b1;
        wait_alive("alive_up");

        // same selection: done next cycle, nothing moves
        req_valid = 1'b1; req_sel = 1'b0;
        step();
        req_valid = 1'b0;
        chk("same_done", 32'(done), 1);
        chk("same_busy", 32'(busy), 0);
        chk("same_pins", 32'({s1, s0}), 32'h1);
        chk("same_rdy", 32'(req_ready), 1);
        step();
        chk("same_pulse", 32'(done), 0);

        // 0 -> 1 with both clocks alive
        ig_seen = 1'b0;
        req_valid = 1'b1; req_sel = 1'b1;
        step();
        req_valid = 1'b0;
        chk("acc_busy", 32'(busy), 1);
        chk("acc_rdy", 32'(req_ready), 0);
        chk("acc_s0", 32'(s0), 1);
        step();
        chk("desel_pins", 32'({s1, s0}), 0);
        repeat (8) step();
        chk("settle_s1", 32'(s1), 0);
        step();
        chk("sel_pins", 32'({s1, s0}), 32'h2);
        wait_done("sw01", 1'b1);
        chk("sw01_busy", 32'(busy), 0);
        step();
        chk("sw01_pulse", 32'(done), 0);
        chk("sw01_noign", 32'(ig_seen), 0);

        do_switch(1'b0);

        // clock 0 dead: ignore0 through the switch
        en0 = 1'b0;
        repeat (90) step();
        chk("dead0", 32'({alive1, alive0}), 32'h2);
        req_valid = 1'b1; req_sel = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("d0_ign_desel", 32'({ignore1, ignore0}), 32'h1);
        repeat (9) step();
        chk("d0_ign_sel", 32'({ignore1, ignore0}), 32'h1);
        wait_done("d0_done", 1'b1);
        chk("d0_ign_clr", 32'({ignore1, ignore0}), 0);

        en0 = 1'b1;
        wait_alive("alive0_back");
        do_switch(1'b0);

        // reset in the middle of SETTLE
        req_valid = 1'b1; req_sel = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (3) step();
        chk("mid_s0", 32'(s0), 0);
        rst_n = 1'b0;
        #1;
        chk("mrst_pins", 32'({s1, s0}), 32'h1);
        chk("mrst_stat", 32'({busy, sel_cur, alive1, alive0}), 0);
        chk("mrst_rdy", 32'(req_ready), 1);
        step();
        rst_n = 1'b1;
        wait_alive("alive_rerst");
        do_switch(1'b1);
        do_switch(1'b0);

        // clock 1 dead: confirm times out and reverts to 0
        en1 = 1'b0;
        repeat (90) step();
        chk("dead1", 32'({alive1, alive0}), 32'h1);
        req_valid = 1'b1; req_sel = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (1034) step();
        chk("to_pre_s1", 32'({s1, s0}), 32'h2);
        step();
        chk("rv_pins", 32'({s1, s0}), 0);
        chk("rv_ign1", 32'(ignore1), 1);
        repeat (7) step();
        chk("rv_hold", 32'({err, s0}), 0);
        step();
        chk("rv_s0", 32'({s1, s0}), 32'h1);
        chk("rv_err", 32'(err), 1);
        chk("rv_sel", 32'(sel_cur), 0);
        chk("rv_ign_clr", 32'(ignore1), 0);
        chk("rv_busy", 32'(busy), 0);
        step();
        chk("rv_pulse", 32'(err), 0);

        chk("s_overlap", 32'(overlap), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
